// File: rtl/jellyvl_etherneco_pkg.sv
// Shared EtherNeco master definitions: scheduler states, packet type codes, gap default.
package jellyvl_etherneco_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_START,
      ST_TX,
      ST_WAIT_RES,
      ST_GAP
   } sched_state_t;

   localparam logic [7:0] PKT_TYPE_SYNCTIMER = 8'h10;
   localparam logic [7:0] PKT_TYPE_GPIO      = 8'h20;
   localparam logic [7:0] PKT_TYPE_REGACC    = 8'h30;

   localparam logic [7:0] DEFAULT_GAP_CYCLES = 8'd12;

   // A single requester still needs a 1-bit index.
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jellyvl_etherneco_rr_arbiter.sv
// Combinational round-robin pick: first pending bit at or after i_rr_ptr, wrapping cyclically.
module jellyvl_etherneco_rr_arbiter
   import jellyvl_etherneco_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = index_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_pending,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic [IDX_W-1:0]   o_index,
   output logic               o_found
);

   logic [IDX_W-1:0] w_pos;

   // Scan from farthest to nearest so the nearest pending requester wins.
   always_comb begin
      o_index = '0;
      o_found = 1'b0;
      w_pos   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_pos = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
         if (i_pending[w_pos]) begin
            o_index = w_pos;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jellyvl_etherneco_cmd_scheduler.sv
// EtherNeco ring command scheduler: one round-robin service round per trigger.
// Response timeout is built only when JELLYVL_ETHERNECO_SCHED_TIMEOUT_EN is defined.
module jellyvl_etherneco_cmd_scheduler
   import jellyvl_etherneco_pkg::*;
#(
   parameter int                       NUM_REQ        = 4,
   parameter int                       TIMEOUT_WIDTH  = 20,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = TIMEOUT_WIDTH'(200000),
   parameter logic [7:0]               GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
   input  logic                     i_rst,
   input  logic                     i_clk,
   input  logic                     i_trigger,
   input  logic [NUM_REQ-1:0]       i_s_req_valid,
   input  logic [NUM_REQ-1:0][7:0]  i_s_req_type,
   input  logic [NUM_REQ-1:0][7:0]  i_s_req_node,
   input  logic [NUM_REQ-1:0][15:0] i_s_req_length,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic                     o_tx_start,
   output logic [7:0]               o_tx_type,
   output logic [7:0]               o_tx_node,
   output logic [15:0]              o_tx_length,
   input  logic                     i_tx_end,
   input  logic                     i_res_rx_end,
   input  logic                     i_res_rx_error,
   input  logic [7:0]               i_res_rx_type,
   output logic [NUM_REQ-1:0]       o_done,
   output logic                     o_done_error,
   output logic                     o_busy,
   output logic                     o_overrun,
   output logic [15:0]              o_overrun_count
);

   localparam int IDX_W = index_width(NUM_REQ);

   sched_state_t         r_state;
   logic [NUM_REQ-1:0]   r_pending;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     r_idx;
   logic [NUM_REQ-1:0]   r_grant;
   logic                 r_tx_start;
   logic [7:0]           r_tx_type;
   logic [7:0]           r_tx_node;
   logic [15:0]          r_tx_length;
   logic [NUM_REQ-1:0]   r_done;
   logic                 r_done_error;
   logic                 r_busy;
   logic                 r_overrun;
   logic [15:0]          r_overrun_count;
   logic [7:0]           r_gap_count;

   logic [IDX_W-1:0]     w_index;
   logic                 w_found;
   logic                 w_res_hit;
   logic                 w_timeout;

   jellyvl_etherneco_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arbiter (
      .i_pending (r_pending),
      .i_rr_ptr  (r_rr_ptr),
      .o_index   (w_index),
      .o_found   (w_found)
   );

   // Responses for a different packet type belong to someone else and are ignored.
   assign w_res_hit = (i_res_rx_end | i_res_rx_error) && (i_res_rx_type == r_tx_type);

`ifdef JELLYVL_ETHERNECO_SCHED_TIMEOUT_EN
   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;

   logic [TIMEOUT_WIDTH-1:0] r_timer;

   always_ff @(posedge i_clk) begin
      if (i_rst || r_state == ST_START) begin
         r_timer <= '0;
      end else if (r_state == ST_TX || r_state == ST_WAIT_RES) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   assign w_timeout = (r_state == ST_TX || r_state == ST_WAIT_RES) && (r_timer == TIMEOUT_LAST);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= ST_IDLE;
         r_pending       <= '0;
         r_rr_ptr        <= '0;
         r_idx           <= '0;
         r_grant         <= '0;
         r_tx_start      <= 1'b0;
         r_tx_type       <= '0;
         r_tx_node       <= '0;
         r_tx_length     <= '0;
         r_done          <= '0;
         r_done_error    <= 1'b0;
         r_busy          <= 1'b0;
         r_overrun       <= 1'b0;
         r_overrun_count <= '0;
         r_gap_count     <= '0;
      end else begin
         r_grant      <= '0;
         r_tx_start   <= 1'b0;
         r_done       <= '0;
         r_done_error <= 1'b0;
         r_overrun    <= 1'b0;

         if (i_trigger && r_state != ST_IDLE) begin
            r_overrun <= 1'b1;
            if (r_overrun_count != 16'hFFFF) begin
               r_overrun_count <= r_overrun_count + 16'd1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (i_trigger && i_s_req_valid != '0) begin
                  r_pending <= i_s_req_valid;
                  r_busy    <= 1'b1;
                  r_state   <= ST_ARB;
               end
            end

            // Outputs are registered here so they are visible during START.
            ST_ARB: begin
               if (w_found) begin
                  r_grant[w_index]   <= 1'b1;
                  r_tx_start         <= 1'b1;
                  r_tx_type          <= i_s_req_type[w_index];
                  r_tx_node          <= i_s_req_node[w_index];
                  r_tx_length        <= i_s_req_length[w_index];
                  r_pending[w_index] <= 1'b0;
                  r_idx              <= w_index;
                  r_rr_ptr           <= (w_index == IDX_W'(NUM_REQ - 1)) ? '0 : w_index + 1'b1;
                  r_state            <= ST_START;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            ST_START: begin
               r_state <= ST_TX;
            end

            ST_TX: begin
               if (w_timeout) begin
                  r_done[r_idx] <= 1'b1;
                  r_done_error  <= 1'b1;
                  r_gap_count   <= '0;
                  r_state       <= ST_GAP;
               end else if (i_tx_end) begin
                  r_state <= ST_WAIT_RES;
               end
            end

            ST_WAIT_RES: begin
               if (w_res_hit || w_timeout) begin
                  r_done[r_idx] <= 1'b1;
                  r_done_error  <= w_res_hit ? i_res_rx_error : 1'b1;
                  r_gap_count   <= '0;
                  r_state       <= ST_GAP;
               end
            end

            // GAP lasts GAP_CYCLES+1 cycles so the next start lands GAP_CYCLES+2 after done.
            ST_GAP: begin
               if (r_gap_count == GAP_CYCLES) begin
                  r_state <= ST_ARB;
               end else begin
                  r_gap_count <= r_gap_count + 8'd1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_grant         = r_grant;
   assign o_tx_start      = r_tx_start;
   assign o_tx_type       = r_tx_type;
   assign o_tx_node       = r_tx_node;
   assign o_tx_length     = r_tx_length;
   assign o_done          = r_done;
   assign o_done_error    = r_done_error;
   assign o_busy          = r_busy;
   assign o_overrun       = r_overrun;
   assign o_overrun_count = r_overrun_count;

endmodule

// File: tb/tb_jellyvl_etherneco_cmd_scheduler.sv
// Directed self-checking bench for jellyvl_etherneco_cmd_scheduler (GAP=3 main instance, GAP=0 second instance).
module tb_jellyvl_etherneco_cmd_scheduler;
   import jellyvl_etherneco_pkg::*;

   localparam int         NUM_REQ = 4;
   localparam logic [7:0] GAP     = 8'd3;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     trigger, trigger0;
   logic [NUM_REQ-1:0]       reqValid;
   logic [NUM_REQ-1:0][7:0]  reqType;
   logic [NUM_REQ-1:0][7:0]  reqNode;
   logic [NUM_REQ-1:0][15:0] reqLength;
   logic                     txEnd, txEnd0;
   logic                     resEnd, resEnd0, resErr, resErr0;
   logic [7:0]               resType;

   logic [NUM_REQ-1:0] grant, grant0, done, done0;
   logic               txStart, txStart0, doneError, doneError0;
   logic [7:0]         txType, txType0, txNode, txNode0;
   logic [15:0]        txLength, txLength0, overrunCount, overrunCount0;
   logic               busy, busy0, overrun, overrun0;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   jellyvl_etherneco_cmd_scheduler #(
      .NUM_REQ(NUM_REQ), .TIMEOUT_WIDTH(20), .TIMEOUT_CYCLES(20'd100), .GAP_CYCLES(GAP)
   ) dut (
      .i_rst(rst), .i_clk(clk), .i_trigger(trigger),
      .i_s_req_valid(reqValid), .i_s_req_type(reqType), .i_s_req_node(reqNode), .i_s_req_length(reqLength),
      .o_grant(grant), .o_tx_start(txStart), .o_tx_type(txType), .o_tx_node(txNode), .o_tx_length(txLength),
      .i_tx_end(txEnd), .i_res_rx_end(resEnd), .i_res_rx_error(resErr), .i_res_rx_type(resType),
      .o_done(done), .o_done_error(doneError), .o_busy(busy), .o_overrun(overrun), .o_overrun_count(overrunCount)
   );

   jellyvl_etherneco_cmd_scheduler #(
      .NUM_REQ(NUM_REQ), .TIMEOUT_WIDTH(20), .TIMEOUT_CYCLES(20'd100), .GAP_CYCLES(8'd0)
   ) dut0 (
      .i_rst(rst), .i_clk(clk), .i_trigger(trigger0),
      .i_s_req_valid(reqValid), .i_s_req_type(reqType), .i_s_req_node(reqNode), .i_s_req_length(reqLength),
      .o_grant(grant0), .o_tx_start(txStart0), .o_tx_type(txType0), .o_tx_node(txNode0), .o_tx_length(txLength0),
      .i_tx_end(txEnd0), .i_res_rx_end(resEnd0), .i_res_rx_error(resErr0), .i_res_rx_type(resType),
      .o_done(done0), .o_done_error(doneError0), .o_busy(busy0), .o_overrun(overrun0), .o_overrun_count(overrunCount0)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
      reqValid = valid;
   endtask

   task automatic pulseTrigger();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
   endtask

   // Waits for tx_start, checks grant/type/wait, then completes the packet normally.
   task automatic serveOne(input string tag, input logic [3:0] expGrant, input logic [7:0] expType,
                           input int expWait);
      int n = 0;
      while (!txStart && n < 40) begin
         tick();
         n++;
      end
      checkOutput({tag, "_start"}, 32'(txStart), 32'd1);
      checkOutput({tag, "_grant"}, 32'(grant), 32'(expGrant));
      checkOutput({tag, "_type"}, 32'(txType), 32'(expType));
      checkOutput({tag, "_wait"}, 32'(n), 32'(expWait));
      tick();
      txEnd = 1'b1;
      tick();
      txEnd   = 1'b0;
      resEnd  = 1'b1;
      resType = expType;
      tick();
      resEnd = 1'b0;
      checkOutput({tag, "_done"}, 32'(done), 32'(expGrant));
      checkOutput({tag, "_err"}, 32'(doneError), 32'd0);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int cnt;
      rst = 1'b1; trigger = 1'b0; trigger0 = 1'b0;
      txEnd = 1'b0; txEnd0 = 1'b0; resEnd = 1'b0; resEnd0 = 1'b0;
      resErr = 1'b0; resErr0 = 1'b0; resType = 8'h00;
      reqValid = '0;
      reqType   = {PKT_TYPE_REGACC, PKT_TYPE_SYNCTIMER, PKT_TYPE_GPIO, PKT_TYPE_SYNCTIMER};
      reqNode   = {8'h04, 8'h05, 8'h02, 8'h01};
      reqLength = {16'h0040, 16'h0007, 16'h0003, 16'h0001};
      repeat (3) tick();

      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_start", 32'(txStart), 32'd0);
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_ovcnt", 32'(overrunCount), 32'd0);
      rst = 1'b0;
      tick();

      // Single requester, response during TX must be ignored.
      applyStimulus(4'b0100);
      pulseTrigger();
      checkOutput("s_busy", 32'(busy), 32'd1);
      checkOutput("s_early", 32'(txStart), 32'd0);
      tick();
      checkOutput("s_start", 32'(txStart), 32'd1);
      checkOutput("s_grant", 32'(grant), 32'h4);
      checkOutput("s_type", 32'(txType), 32'h10);
      checkOutput("s_node", 32'(txNode), 32'h05);
      checkOutput("s_len", 32'(txLength), 32'h0007);
      applyStimulus(4'b0000);
      tick();
      resEnd = 1'b1; resType = 8'h10;
      tick();
      resEnd = 1'b0;
      checkOutput("s_txres", 32'(done), 32'd0);
      checkOutput("s_hold", 32'(txType), 32'h10);
      txEnd = 1'b1;
      tick();
      txEnd = 1'b0;
      resEnd = 1'b1; resType = 8'h10;
      tick();
      resEnd = 1'b0;
      checkOutput("s_done", 32'(done), 32'h4);
      checkOutput("s_err", 32'(doneError), 32'd0);
      repeat (4) tick();
      checkOutput("s_busy_arb", 32'(busy), 32'd1);
      tick();
      checkOutput("s_busy_end", 32'(busy), 32'd0);

      // Empty snapshot.
      applyStimulus(4'b0000);
      pulseTrigger();
      checkOutput("e_busy1", 32'(busy), 32'd0);
      tick();
      checkOutput("e_start", 32'(txStart), 32'd0);
      checkOutput("e_busy2", 32'(busy), 32'd0);

      // Round robin from a reset pointer, then pointer continuing at 2.
      doReset();
      applyStimulus(4'b1011);
      pulseTrigger();
      serveOne("r1a", 4'b0001, 8'h10, 1);
      serveOne("r1b", 4'b0010, 8'h20, GAP + 2);
      serveOne("r1c", 4'b1000, 8'h30, GAP + 2);
      waitIdle("r1");
      applyStimulus(4'b0011);
      pulseTrigger();
      serveOne("r2a", 4'b0001, 8'h10, 1);
      serveOne("r2b", 4'b0010, 8'h20, GAP + 2);
      waitIdle("r2");
      applyStimulus(4'b1011);
      pulseTrigger();
      serveOne("r3a", 4'b1000, 8'h30, 1);
      serveOne("r3b", 4'b0001, 8'h10, GAP + 2);
      serveOne("r3c", 4'b0010, 8'h20, GAP + 2);
      waitIdle("r3");

      // Zero gap, simultaneous end+error counts as error.
      applyStimulus(4'b0011);
      trigger0 = 1'b1;
      tick();
      trigger0 = 1'b0;
      tick();
      checkOutput("g0_start", 32'(txStart0), 32'd1);
      checkOutput("g0_grant", 32'(grant0), 32'h1);
      tick();
      txEnd0 = 1'b1;
      tick();
      txEnd0 = 1'b0;
      resEnd0 = 1'b1; resErr0 = 1'b1; resType = 8'h10;
      tick();
      resEnd0 = 1'b0; resErr0 = 1'b0;
      checkOutput("g0_done", 32'(done0), 32'h1);
      checkOutput("g0_err", 32'(doneError0), 32'd1);
      tick();
      checkOutput("g0_nostart", 32'(txStart0), 32'd0);
      tick();
      checkOutput("g0_start2", 32'(txStart0), 32'd1);
      checkOutput("g0_grant2", 32'(grant0), 32'h2);
      applyStimulus(4'b0000);

      // Mismatched response type, then silence.
      applyStimulus(4'b0100);
      pulseTrigger();
      tick();
      checkOutput("t_grant", 32'(grant), 32'h4);
      applyStimulus(4'b0000);
      cnt = 0;
`ifdef JELLYVL_ETHERNECO_SCHED_TIMEOUT_EN
      while (done == '0 && cnt < 300) begin
         tick();
         cnt++;
         txEnd   = (cnt == 1);
         resEnd  = (cnt == 2);
         resType = 8'h55;
      end
      checkOutput("t_cycles", 32'(cnt), 32'd101);
      checkOutput("t_done", 32'(done), 32'h4);
      checkOutput("t_err", 32'(doneError), 32'd1);
      waitIdle("t");
`else
      while (done == '0 && cnt < 150) begin
         tick();
         cnt++;
         txEnd   = (cnt == 1);
         resEnd  = (cnt == 2);
         resType = 8'h55;
      end
      checkOutput("t_nodone", 32'(cnt), 32'd150);
      checkOutput("t_busy", 32'(busy), 32'd1);
      doReset();
`endif
      txEnd = 1'b0; resEnd = 1'b0;

      // Three overruns while waiting for a response.
      applyStimulus(4'b0010);
      pulseTrigger();
      tick();
      checkOutput("o_start", 32'(txStart), 32'd1);
      applyStimulus(4'b0000);
      tick();
      txEnd = 1'b1;
      tick();
      txEnd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pulseTrigger();
         checkOutput("o_pulse", 32'(overrun), 32'd1);
         tick();
      end
      checkOutput("o_quiet", 32'(overrun), 32'd0);
      checkOutput("o_count", 32'(overrunCount), 32'd3);
      checkOutput("o_busy", 32'(busy), 32'd1);
      resEnd = 1'b1; resType = 8'h20;
      tick();
      resEnd = 1'b0;
      checkOutput("o_done", 32'(done), 32'h2);
      checkOutput("o_err", 32'(doneError), 32'd0);
      waitIdle("o");

      // Reset while in TX.
      applyStimulus(4'b1000);
      pulseTrigger();
      tick();
      checkOutput("x_grant", 32'(grant), 32'h8);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("x_busy", 32'(busy), 32'd0);
      checkOutput("x_grant0", 32'(grant), 32'd0);
      checkOutput("x_type", 32'(txType), 32'd0);
      checkOutput("x_len", 32'(txLength), 32'd0);
      checkOutput("x_ovcnt", 32'(overrunCount), 32'd0);
      applyStimulus(4'b1111);
      pulseTrigger();
      checkOutput("x_busy2", 32'(busy), 32'd1);
      tick();
      checkOutput("x_start", 32'(txStart), 32'd1);
      checkOutput("x_ptr0", 32'(grant), 32'h1);
      checkOutput("x_nodone", 32'(done), 32'd0);
      doReset();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
